// File: rtl/riscv_defs_pkg.sv
// -----------------------------------------------------------------------------
// riscv_defs_pkg
//   Shared RV32I pipeline definitions: datapath width, instruction width,
//   reset PC, bubble instruction, fetch-mode encoding and a small helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package riscv_defs_pkg;

   localparam int          XLEN      = 32;
   localparam int          INSTR_W   = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

   // Fetch mode; HALT is only reachable when the misaligned-target trap is built in.
   typedef enum logic {
      MODE_RUN  = 1'b0,
      MODE_HALT = 1'b1
   } fetch_mode_e;

   // A target is misaligned when either of its two low address bits is set.
   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return (low_bits != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Async active-high reset and synchronous flush both
//   load a bubble {pc=0, pc+4=0, NOP_INSTR, valid=0}; hold keeps every field
//   (including a bubble already held); otherwise the fetched word is captured.
//   Flush has priority over hold.
// Ports
//   clk, reset          clock, async active-high reset
//   hold, flush         keep contents / load bubble
//   in_pc, in_pc_plus4  PC of the fetched word and its link value
//   in_instr            fetched instruction word
//   pc, pc_plus4, instr, valid   registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_reg
   import riscv_defs_pkg::*;
#(
   parameter int          XLEN_P      = XLEN,
   parameter logic [31:0] NOP_INSTR_P = NOP_INSTR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                hold,
   input  logic                flush,
   input  logic [XLEN_P-1:0]   in_pc,
   input  logic [XLEN_P-1:0]   in_pc_plus4,
   input  logic [INSTR_W-1:0]  in_instr,
   output logic [XLEN_P-1:0]   pc,
   output logic [XLEN_P-1:0]   pc_plus4,
   output logic [INSTR_W-1:0]  instr,
   output logic                valid
);

   // IF/ID register: bubble on reset/flush, hold on stall, capture otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= '0;
         pc_plus4 <= '0;
         instr    <= NOP_INSTR_P;
         valid    <= 1'b0;
      end else if (flush) begin
         pc       <= '0;
         pc_plus4 <= '0;
         instr    <= NOP_INSTR_P;
         valid    <= 1'b0;
      end else if (hold) begin
         pc       <= pc;
         pc_plus4 <= pc_plus4;
         instr    <= instr;
         valid    <= valid;
      end else begin
         pc       <= in_pc;
         pc_plus4 <= in_pc_plus4;
         instr    <= in_instr;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   IF stage of the 5-stage RV32I pipeline. Owns the PC, presents it to the
//   asynchronous-read instruction memory and captures the returned word into
//   the IF/ID register one edge later. Per edge: redirect > stall > advance.
//   Build option: FETCH_MISALIGN_TRAP_EN -- a redirect to a target with
//   non-zero low bits sets sticky fetch_fault and parks the stage in HALT
//   (pc holds, bubbles every cycle, stall ignored) until reset. Without it the
//   target's low two bits are masked and fetch_fault is tied low.
// Ports
//   clk, reset        clock, async active-high reset
//   stall             hold PC and IF/ID
//   redirect          flush IF/ID and load redirect_target
//   redirect_target   new PC
//   imem_addr         instruction memory byte address (== pc)
//   imem_instr        word returned by instruction memory this cycle
//   if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid   IF/ID contents
//   fetch_fault       sticky misaligned-target flag
// -----------------------------------------------------------------------------
module fetch_stage
   import riscv_defs_pkg::*;
#(
   parameter int          XLEN_P      = XLEN,
   parameter logic [31:0] RESET_PC_P  = RESET_PC,
   parameter logic [31:0] NOP_INSTR_P = NOP_INSTR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                redirect,
   input  logic [XLEN_P-1:0]   redirect_target,
   output logic [XLEN_P-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_instr,
   output logic [XLEN_P-1:0]   if_id_pc,
   output logic [XLEN_P-1:0]   if_id_pc_plus4,
   output logic [INSTR_W-1:0]  if_id_instr,
   output logic                if_id_valid,
   output logic                fetch_fault
);

   localparam logic [XLEN_P-1:0] ADDR_MASK = ~(XLEN_P'(3));

   logic [XLEN_P-1:0] pc_r;
   logic [XLEN_P-1:0] pc_next_s;
   logic [XLEN_P-1:0] pc_plus4_s;
   logic              hold_s;
   logic              flush_s;

   assign pc_plus4_s = pc_r + XLEN_P'(4);   // wraps modulo 2^XLEN
   assign imem_addr  = pc_r;

`ifdef FETCH_MISALIGN_TRAP_EN
   fetch_mode_e mode_r;
   fetch_mode_e mode_next_s;
   logic        fault_r;

   // Fetch-mode and sticky fault registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_r  <= MODE_RUN;
         fault_r <= 1'b0;
      end else begin
         mode_r  <= mode_next_s;
         fault_r <= fault_r | (mode_next_s == MODE_HALT);
      end
   end

   // Next-PC, IF/ID control and fetch-mode transition.
   always_comb begin
      pc_next_s   = pc_r;
      hold_s      = 1'b0;
      flush_s     = 1'b0;
      mode_next_s = mode_r;
      case (mode_r)
         MODE_HALT: begin
            flush_s = 1'b1;              // bubbles forever, stall ignored
         end
         MODE_RUN: begin
            if (redirect) begin
               flush_s = 1'b1;
               if (is_misaligned(redirect_target[1:0])) begin
                  mode_next_s = MODE_HALT;   // pc holds its current value
               end else begin
                  pc_next_s = redirect_target;
               end
            end else if (stall) begin
               hold_s = 1'b1;
            end else begin
               pc_next_s = pc_plus4_s;
            end
         end
         default: begin
            mode_next_s = MODE_RUN;
         end
      endcase
   end

   assign fetch_fault = fault_r;
`else
   // Next-PC and IF/ID control; misaligned target bits are silently dropped.
   always_comb begin
      pc_next_s = pc_r;
      hold_s    = 1'b0;
      flush_s   = 1'b0;
      if (redirect) begin
         flush_s   = 1'b1;
         pc_next_s = redirect_target & ADDR_MASK;
      end else if (stall) begin
         hold_s = 1'b1;
      end else begin
         pc_next_s = pc_plus4_s;
      end
   end

   assign fetch_fault = 1'b0;
`endif

   // Program counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r <= RESET_PC_P & ADDR_MASK;
      end else begin
         pc_r <= pc_next_s;
      end
   end

   if_id_reg #(
      .XLEN_P      (XLEN_P),
      .NOP_INSTR_P (NOP_INSTR_P)
   ) u_if_id_reg (
      .clk         (clk),
      .reset       (reset),
      .hold        (hold_s),
      .flush       (flush_s),
      .in_pc       (pc_r),
      .in_pc_plus4 (pc_plus4_s),
      .in_instr    (imem_instr),
      .pc          (if_id_pc),
      .pc_plus4    (if_id_pc_plus4),
      .instr       (if_id_instr),
      .valid       (if_id_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. The instruction memory returns a word
//   derived from the address so captured instructions can be told apart.
//   Honours FETCH_MISALIGN_TRAP_EN for the misaligned-redirect case.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        fetch_fault;

   int n_checks;
   int n_pass;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_stage dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .if_id_pc        (if_id_pc),
      .if_id_pc_plus4  (if_id_pc_plus4),
      .if_id_instr     (if_id_instr),
      .if_id_valid     (if_id_valid),
      .fetch_fault     (fetch_fault)
   );

   // Instruction memory contents: upper half is the inverted low address half.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign imem_instr = mem_word(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_if_id(input string tag, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic [31:0] ins,
                              input logic v);
      check({tag, ".pc"},    if_id_pc,       pc);
      check({tag, ".pc4"},   if_id_pc_plus4, pc4);
      check({tag, ".instr"}, if_id_instr,    ins);
      check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".addr"},  imem_addr, 32'h0);
      check_if_id(tag, 32'h0, 32'h0, NOP, 1'b0);
      check({tag, ".fault"}, {31'd0, fetch_fault}, 32'h0);
   endtask

   initial begin
      n_checks        = 0;
      n_pass          = 0;
      reset           = 1'b1;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_target = 32'h0;

      // 1: reset held three cycles, then free-running fetch
      tick(); tick(); tick();
      check_reset_state("rst");
      reset = 1'b0;
      tick();
      check("t1.addr4", imem_addr, 32'h4);
      check_if_id("t1.e1", 32'h0, 32'h4, mem_word(32'h0), 1'b1);
      tick();
      check("t1.addr8", imem_addr, 32'h8);
      check_if_id("t1.e2", 32'h4, 32'h8, mem_word(32'h4), 1'b1);

      // 2: two-cycle stall at pc=8
      stall = 1'b1;
      tick();
      check("t2.s1.addr", imem_addr, 32'h8);
      check_if_id("t2.s1", 32'h4, 32'h8, mem_word(32'h4), 1'b1);
      tick();
      check("t2.s2.addr", imem_addr, 32'h8);
      check_if_id("t2.s2", 32'h4, 32'h8, mem_word(32'h4), 1'b1);
      stall = 1'b0;
      tick();
      check("t2.res.addr", imem_addr, 32'hC);
      check_if_id("t2.res", 32'h8, 32'hC, mem_word(32'h8), 1'b1);

      // 3: redirect to 0x48 from pc=0x18
      tick(); tick(); tick();
      check("t3.pre.addr", imem_addr, 32'h18);
      redirect        = 1'b1;
      redirect_target = 32'h48;
      tick();
      check("t3.addr", imem_addr, 32'h48);
      check_if_id("t3.bub", 32'h0, 32'h0, NOP, 1'b0);
      redirect = 1'b0;
      tick();
      check("t3.next.addr", imem_addr, 32'h4C);
      check_if_id("t3.next", 32'h48, 32'h4C, mem_word(32'h48), 1'b1);

      // 4: redirect and stall together, redirect wins
      redirect        = 1'b1;
      stall           = 1'b1;
      redirect_target = 32'h60;
      tick();
      check("t4.addr", imem_addr, 32'h60);
      check_if_id("t4.bub", 32'h0, 32'h0, NOP, 1'b0);

      // stall while a bubble is held keeps the bubble
      redirect = 1'b0;
      tick();
      check("t4.hold.addr", imem_addr, 32'h60);
      check_if_id("t4.hold", 32'h0, 32'h0, NOP, 1'b0);
      stall = 1'b0;

      // 5: wrap from 0xFFFFFFFC
      redirect        = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      tick();
      check("t5.addr", imem_addr, 32'hFFFF_FFFC);
      redirect = 1'b0;
      tick();
      check("t5.wrap.addr", imem_addr, 32'h0);
      check_if_id("t5.wrap", 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1);

      // 6: misaligned redirect target 0x4A from pc=0
      redirect        = 1'b1;
      redirect_target = 32'h4A;
      tick();
      redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      check("t6.addr", imem_addr, 32'h0);
      check("t6.fault", {31'd0, fetch_fault}, 32'h1);
      check_if_id("t6.bub", 32'h0, 32'h0, NOP, 1'b0);
      tick();
      check("t6.halt.addr", imem_addr, 32'h0);
      check("t6.halt.fault", {31'd0, fetch_fault}, 32'h1);
      check_if_id("t6.halt", 32'h0, 32'h0, NOP, 1'b0);
`else
      check("t6.addr", imem_addr, 32'h48);
      check("t6.fault", {31'd0, fetch_fault}, 32'h0);
      check_if_id("t6.bub", 32'h0, 32'h0, NOP, 1'b0);
      tick();
      check("t6.next.addr", imem_addr, 32'h4C);
      check_if_id("t6.next", 32'h48, 32'h4C, mem_word(32'h48), 1'b1);
`endif

      // asynchronous reset mid-cycle while stall and redirect are active
      stall           = 1'b1;
      redirect        = 1'b1;
      redirect_target = 32'h30;
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("arst");
      tick();
      check_reset_state("arst.held");
      stall    = 1'b0;
      redirect = 1'b0;
      reset    = 1'b0;
      tick();
      check("post.addr", imem_addr, 32'h4);
      check_if_id("post", 32'h0, 32'h4, mem_word(32'h0), 1'b1);
      check("post.fault", {31'd0, fetch_fault}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
